// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped L1 data cache.
package dcache_pkg;

  localparam int NUM_LINES_DEF = 32;
  localparam int LINE_BITS     = 256;
  localparam int TAG_W         = 22;
  localparam int INDEX_W       = 5;
  localparam int OFFSET_W      = 5;
  localparam int WORD_SEL_W    = 3;
  localparam int WORD_LSB      = 2;
  localparam int INDEX_LSB     = OFFSET_W;
  localparam int TAG_LSB       = OFFSET_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    READMISS  = 2'd2,
    REFILLED  = 2'd3
  } state_t;

  typedef logic [TAG_W-1:0]      tag_t;
  typedef logic [INDEX_W-1:0]    index_t;
  typedef logic [WORD_SEL_W-1:0] wordSel_t;

  function automatic tag_t addrTag(input logic [31:0] addr);
    return addr[31:TAG_LSB];
  endfunction

  function automatic index_t addrIndex(input logic [31:0] addr);
    return addr[TAG_LSB-1:INDEX_LSB];
  endfunction

  function automatic wordSel_t addrWord(input logic [31:0] addr);
    return addr[INDEX_LSB-1:WORD_LSB];
  endfunction

  function automatic logic [31:0] lineAddr(input tag_t tag, input index_t index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side buses of the data cache; master drives the request.
interface dcache_cpu_if;
  import dcache_pkg::*;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_MemRead_i;
  logic        cpu_MemWrite_i;
  logic [31:0] cpu_data_o;
  logic        cpu_stall_o;

  modport master (output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
                  input  cpu_data_o, cpu_stall_o);
  modport slave  (input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
                  output cpu_data_o, cpu_stall_o);
endinterface

interface dcache_mem_if;
  import dcache_pkg::*;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  modport master (output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
                  input  mem_data_i, mem_ack_i);
  modport slave  (input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
                  output mem_data_i, mem_ack_i);
endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous line-fill, word-merge and clean ports.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int LINE_W    = LINE_BITS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  index_t            rdIndex,
  output logic              rdValid,
  output logic              rdDirty,
  output tag_t              rdTag,
  output logic [LINE_W-1:0] rdLine,
  input  logic              fillEn,
  input  index_t            fillIndex,
  input  tag_t              fillTag,
  input  logic [LINE_W-1:0] fillLine,
  input  logic              mergeEn,
  input  index_t            mergeIndex,
  input  wordSel_t          mergeWord,
  input  logic [31:0]       mergeData,
  input  logic              cleanEn,
  input  index_t            cleanIndex
);

  logic [NUM_LINES-1:0] validArr;
  logic [NUM_LINES-1:0] dirtyArr;
  tag_t                 tagArr  [NUM_LINES];
  logic [LINE_W-1:0]    dataArr [NUM_LINES];

  assign rdValid = validArr[rdIndex];
  assign rdDirty = dirtyArr[rdIndex];
  assign rdTag   = tagArr[rdIndex];
  assign rdLine  = dataArr[rdIndex];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      validArr <= '0;
      dirtyArr <= '0;
    end else begin
      if (fillEn) begin
        validArr[fillIndex] <= 1'b1;
        dirtyArr[fillIndex] <= 1'b0;
      end
      if (mergeEn)
        dirtyArr[mergeIndex] <= 1'b1;
      if (cleanEn)
        dirtyArr[cleanIndex] <= 1'b0;
    end
  end

  // Tag and data contents are qualified by valid, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (fillEn) begin
      tagArr[fillIndex]  <= fillTag;
      dataArr[fillIndex] <= fillLine;
    end
    if (mergeEn)
      dataArr[mergeIndex][{mergeWord, 5'b0} +: 32] <= mergeData;
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 data cache controller for the MEM stage.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int LINE_W    = LINE_BITS
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dcache_cpu_if.slave   cpu,
  dcache_mem_if.master  mem
);

  state_t            state;
  tag_t              missTag;
  index_t            missIndex;

  tag_t              reqTag;
  index_t            reqIndex;
  wordSel_t          reqWord;
  logic              rdValid;
  logic              rdDirty;
  tag_t              rdTag;
  logic [LINE_W-1:0] rdLine;
  logic              req;
  logic              hit;
  logic              fillEn;
  logic              mergeEn;
  logic              cleanEn;
  logic [1:0]        unusedAddrBits;

  assign reqTag         = addrTag(cpu.cpu_addr_i);
  assign reqIndex       = addrIndex(cpu.cpu_addr_i);
  assign reqWord        = addrWord(cpu.cpu_addr_i);
  assign unusedAddrBits = cpu.cpu_addr_i[1:0];

  assign req = cpu.cpu_MemRead_i | cpu.cpu_MemWrite_i;
  assign hit = req & rdValid & (rdTag == reqTag);

  assign cpu.cpu_stall_o = req & ~hit;
  assign cpu.cpu_data_o  = hit ? rdLine[{reqWord, 5'b0} +: 32] : 32'd0;

  // Fill and clean use the latched miss address so a dropped request still completes.
  assign fillEn  = (state == READMISS) & mem.mem_ack_i;
  assign cleanEn = (state == WRITEBACK) & mem.mem_ack_i;
  assign mergeEn = cpu.cpu_MemWrite_i & hit & ((state == IDLE) | (state == REFILLED));

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_W)
  ) sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rdIndex    (reqIndex),
    .rdValid    (rdValid),
    .rdDirty    (rdDirty),
    .rdTag      (rdTag),
    .rdLine     (rdLine),
    .fillEn     (fillEn),
    .fillIndex  (missIndex),
    .fillTag    (missTag),
    .fillLine   (mem.mem_data_i),
    .mergeEn    (mergeEn),
    .mergeIndex (reqIndex),
    .mergeWord  (reqWord),
    .mergeData  (cpu.cpu_data_i),
    .cleanEn    (cleanEn),
    .cleanIndex (missIndex)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state            <= IDLE;
      missTag          <= '0;
      missIndex        <= '0;
      mem.mem_addr_o   <= '0;
      mem.mem_data_o   <= '0;
      mem.mem_enable_o <= 1'b0;
      mem.mem_write_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            missTag          <= reqTag;
            missIndex        <= reqIndex;
            mem.mem_enable_o <= 1'b1;
            if (rdValid && rdDirty) begin
              mem.mem_write_o <= 1'b1;
              mem.mem_addr_o  <= lineAddr(rdTag, reqIndex);
              mem.mem_data_o  <= rdLine;
              state           <= WRITEBACK;
            end else begin
              mem.mem_write_o <= 1'b0;
              mem.mem_addr_o  <= lineAddr(reqTag, reqIndex);
              state           <= READMISS;
            end
          end
        end
        WRITEBACK: begin
          if (mem.mem_ack_i) begin
            mem.mem_write_o <= 1'b0;
            mem.mem_addr_o  <= lineAddr(missTag, missIndex);
            state           <= READMISS;
          end
        end
        READMISS: begin
          if (mem.mem_ack_i) begin
            mem.mem_enable_o <= 1'b0;
            state            <= REFILLED;
          end
        end
        REFILLED: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: hit/miss timing, write-back, store-allocate, reset and stray acks.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  dcache_cpu_if cpuBus ();
  dcache_mem_if memBus ();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .cpu   (cpuBus),
    .mem   (memBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    cpuBus.cpu_MemRead_i  = rd;
    cpuBus.cpu_MemWrite_i = wr;
    cpuBus.cpu_addr_i     = addr;
    cpuBus.cpu_data_i     = data;
  endtask

  logic [255:0] line1, wbLine1, line2, line3, evictLine3, line4, junk;

  initial begin
    line1      = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
                  32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    wbLine1    = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444,
                  32'h33333333, 32'h22222222, 32'h12345678, 32'hDEADBEEF};
    line2      = {32'hA0000007, 32'hA0000006, 32'hA0000005, 32'hA0000004,
                  32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    line3      = {32'hB0000007, 32'hB0000006, 32'hB0000005, 32'hB0000004,
                  32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
    evictLine3 = {32'hB0000007, 32'hB0000006, 32'hB0000005, 32'hB0000004,
                  32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hCAFEF00D};
    line4      = {32'hC0000007, 32'hC0000006, 32'hC0000005, 32'hC0000004,
                  32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
    junk       = {8{32'hFFFFFFFF}};
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    memBus.mem_ack_i  = 1'b0;
    memBus.mem_data_i = '0;

    @(negedge clk);
    checkVal("rst_stall", cpuBus.cpu_stall_o, 0);
    checkVal("rst_en",    memBus.mem_enable_o, 0);
    checkVal("rst_wr",    memBus.mem_write_o, 0);
    checkVal("rst_addr",  memBus.mem_addr_o, 0);
    checkVal("rst_data",  memBus.mem_data_o, 0);
    checkVal("rst_cpuo",  cpuBus.cpu_data_o, 0);
    step();
    rst_n = 1'b1;

    // Clean load miss at 0x40, ack in cycle 4
    step(); drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    @(negedge clk);
    checkVal("m0_stall_c0", cpuBus.cpu_stall_o, 1);
    checkVal("m0_en_c0",    memBus.mem_enable_o, 0);
    step(); @(negedge clk);
    checkVal("m0_en_c1",    memBus.mem_enable_o, 1);
    checkVal("m0_wr_c1",    memBus.mem_write_o, 0);
    checkVal("m0_addr_c1",  memBus.mem_addr_o, 32'h0000_0040);
    checkVal("m0_stall_c1", cpuBus.cpu_stall_o, 1);
    step(); @(negedge clk);
    checkVal("m0_stall_c2", cpuBus.cpu_stall_o, 1);
    step(); @(negedge clk);
    checkVal("m0_stall_c3", cpuBus.cpu_stall_o, 1);
    step(); memBus.mem_ack_i = 1'b1; memBus.mem_data_i = line1;
    @(negedge clk);
    checkVal("m0_stall_c4", cpuBus.cpu_stall_o, 1);
    step(); memBus.mem_ack_i = 1'b0; memBus.mem_data_i = '0;
    @(negedge clk);
    checkVal("m0_stall_c5", cpuBus.cpu_stall_o, 0);
    checkVal("m0_data_c5",  cpuBus.cpu_data_o, 32'hDEADBEEF);
    checkVal("m0_en_c5",    memBus.mem_enable_o, 0);

    // Store hit, then loads of the same line
    step(); drive(1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678);
    @(negedge clk);
    checkVal("st_hit_stall", cpuBus.cpu_stall_o, 0);
    step(); drive(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    @(negedge clk);
    checkVal("ld44_stall", cpuBus.cpu_stall_o, 0);
    checkVal("ld44_data",  cpuBus.cpu_data_o, 32'h1234_5678);
    step(); drive(1'b1, 1'b0, 32'h0000_0048, 32'h0);
    @(negedge clk);
    checkVal("ld48_data",  cpuBus.cpu_data_o, 32'h2222_2222);

    // Dirty conflict miss at 0x440 forces write-back of 0x40
    step(); drive(1'b1, 1'b0, 32'h0000_0440, 32'h0);
    @(negedge clk);
    checkVal("wb_stall_c0", cpuBus.cpu_stall_o, 1);
    step(); @(negedge clk);
    checkVal("wb_en",    memBus.mem_enable_o, 1);
    checkVal("wb_wr",    memBus.mem_write_o, 1);
    checkVal("wb_addr",  memBus.mem_addr_o, 32'h0000_0040);
    checkVal("wb_data",  memBus.mem_data_o, wbLine1);
    step(); memBus.mem_ack_i = 1'b1;
    @(negedge clk);
    checkVal("wb_hold_wr", memBus.mem_write_o, 1);
    step(); memBus.mem_ack_i = 1'b0;
    @(negedge clk);
    checkVal("wbf_en",    memBus.mem_enable_o, 1);
    checkVal("wbf_wr",    memBus.mem_write_o, 0);
    checkVal("wbf_addr",  memBus.mem_addr_o, 32'h0000_0440);
    checkVal("wbf_stall", cpuBus.cpu_stall_o, 1);
    step(); memBus.mem_ack_i = 1'b1; memBus.mem_data_i = line2;
    @(negedge clk);
    step(); memBus.mem_ack_i = 1'b0; memBus.mem_data_i = '0;
    @(negedge clk);
    checkVal("wbf_stall_done", cpuBus.cpu_stall_o, 0);
    checkVal("wbf_data",       cpuBus.cpu_data_o, 32'hA000_0000);

    // Store miss to a clean line at 0x80, merged in REFILLED
    step(); drive(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D);
    @(negedge clk);
    checkVal("sm_stall_c0", cpuBus.cpu_stall_o, 1);
    step(); memBus.mem_ack_i = 1'b1; memBus.mem_data_i = line3;
    @(negedge clk);
    checkVal("sm_en",   memBus.mem_enable_o, 1);
    checkVal("sm_wr",   memBus.mem_write_o, 0);
    checkVal("sm_addr", memBus.mem_addr_o, 32'h0000_0080);
    step(); memBus.mem_ack_i = 1'b0; memBus.mem_data_i = '0;
    @(negedge clk);
    checkVal("sm_refilled_stall", cpuBus.cpu_stall_o, 0);
    step(); drive(1'b1, 1'b0, 32'h0000_0080, 32'h0);
    @(negedge clk);
    checkVal("sm_ld80", cpuBus.cpu_data_o, 32'hCAFE_F00D);
    checkVal("sm_ld80_stall", cpuBus.cpu_stall_o, 0);
    step(); drive(1'b1, 1'b0, 32'h0000_0084, 32'h0);
    @(negedge clk);
    checkVal("sm_ld84", cpuBus.cpu_data_o, 32'hB000_0001);

    // Evict 0x80: must write back the merged word, proving dirty was set
    step(); drive(1'b1, 1'b0, 32'h0000_0480, 32'h0);
    @(negedge clk);
    checkVal("ev_stall", cpuBus.cpu_stall_o, 1);
    step(); memBus.mem_ack_i = 1'b1;
    @(negedge clk);
    checkVal("ev_wr",   memBus.mem_write_o, 1);
    checkVal("ev_addr", memBus.mem_addr_o, 32'h0000_0080);
    checkVal("ev_data", memBus.mem_data_o, evictLine3);
    step(); memBus.mem_ack_i = 1'b0;
    @(negedge clk);
    checkVal("ev_fill_addr", memBus.mem_addr_o, 32'h0000_0480);
    checkVal("ev_fill_en",   memBus.mem_enable_o, 1);

    // Reset while in READMISS
    step(); rst_n = 1'b0;
    #1;
    checkVal("rm_rst_en",   memBus.mem_enable_o, 0);
    checkVal("rm_rst_addr", memBus.mem_addr_o, 0);
    @(negedge clk);
    step(); rst_n = 1'b1; drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    @(negedge clk);
    checkVal("post_rst_miss", cpuBus.cpu_stall_o, 1);
    step(); memBus.mem_ack_i = 1'b1; memBus.mem_data_i = line4;
    @(negedge clk);
    checkVal("post_rst_en",   memBus.mem_enable_o, 1);
    checkVal("post_rst_addr", memBus.mem_addr_o, 32'h0000_0040);
    checkVal("post_rst_wr",   memBus.mem_write_o, 0);
    step(); memBus.mem_ack_i = 1'b0; memBus.mem_data_i = '0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkVal("post_rst_en_off", memBus.mem_enable_o, 0);

    // Stray ack in IDLE
    step(); memBus.mem_ack_i = 1'b1; memBus.mem_data_i = junk;
    @(negedge clk);
    checkVal("stray_stall", cpuBus.cpu_stall_o, 0);
    step(); memBus.mem_ack_i = 1'b0; memBus.mem_data_i = '0;
    @(negedge clk);
    checkVal("stray_en", memBus.mem_enable_o, 0);
    checkVal("stray_wr", memBus.mem_write_o, 0);
    step(); drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    @(negedge clk);
    checkVal("stray_hit_stall", cpuBus.cpu_stall_o, 0);
    checkVal("stray_hit_data",  cpuBus.cpu_data_o, 32'hC000_0000);
    step(); drive(1'b1, 1'b0, 32'h0000_00C0, 32'h0);
    @(negedge clk);
    checkVal("stray_no_install", cpuBus.cpu_stall_o, 1);
    step(); drive(1'b0, 1'b0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

L1 data-cache controller for the MEM stage, downstream of the EX/MEM pipeline register. It consumes that register's MemRead/MemWrite/ALU_result/read_data_2 outputs and returns load data to MEM/WB. It drives the memory-stall signal that freezes EX/MEM and the earlier stages. The cache is direct-mapped, write-back and write-allocate, and sits in front of a 256-bit-line data memory with a request/ack handshake.

## Interface
Parameters:
- NUM_LINES, 32: cache lines; index width = log2(NUM_LINES) = 5.
- LINE_BITS, 256: line size (32 bytes, 8 words); offset width 5.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- cpu_addr_i  in  32  byte address (ALU_result).
- cpu_data_i  in  32  store data (read_data_2).
- cpu_MemRead_i  in  1  load request.
- cpu_MemWrite_i  in  1  store request; never high together with cpu_MemRead_i.
- cpu_data_o  out  32  load data, combinational on hit.
- cpu_stall_o  out  1  MemStall to pipeline registers, combinational.
- mem_addr_o  out  32  line-aligned memory address, registered.
- mem_data_o  out  256  write-back line, registered.
- mem_enable_o  out  1  memory request, registered.
- mem_write_o  out  1  1 = write-back, 0 = line fill, registered.
- mem_data_i  in  256  fill data, valid with mem_ack_i.
- mem_ack_i  in  1  one-cycle completion pulse.

## Operation
- Address split: word = addr[4:2], index = addr[9:5], tag = addr[31:10] (22 bits). addr[1:0] is ignored; access is word only.
- Per-line state: valid, dirty, tag[21:0], data[255:0].
- req = MemRead | MemWrite. hit = req & valid[index] & (tag[index] == tag).
- cpu_stall_o = req & ~hit. It is combinational in every state.
- cpu_data_o = data[index] word[word] when hit. Otherwise it is 0.
- Store hit with the FSM in IDLE or REFILLED: at the clock edge, merge the word into the line and set dirty = 1.
- FSM states: IDLE, WRITEBACK, READMISS, REFILLED.
  - IDLE, req & ~hit, victim valid & dirty → WRITEBACK. Drive mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line.
  - IDLE, req & ~hit, victim clean or invalid → READMISS. Drive mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {tag, index, 5'b0}.
  - WRITEBACK: hold all mem outputs until mem_ack_i. Then → READMISS with the fill request issued as above. Clear the victim's dirty bit.
  - READMISS: hold until mem_ack_i. Then write mem_data_i into the line with valid = 1, dirty = 0 and the new tag. Set mem_enable_o = 0 and go to REFILLED.
  - REFILLED: the line now hits and stall drops. A pending store merges and sets dirty. Always → IDLE next cycle.
- mem_ack_i is ignored in IDLE and REFILLED.
- The CPU holds its request stable while stalled. If the request drops mid-miss, the FSM still completes the memory transaction and installs the line.

## Timing
- Reset (rst_i low, asynchronous) sets state = IDLE, every valid and dirty bit = 0, and mem_enable_o = mem_write_o = 0.
- Reset also sets mem_addr_o = 0 and mem_data_o = 0. Tag and data arrays need no reset.
- Reset mid-miss abandons the transaction. Memory outputs drop immediately.
- Hit: zero stall cycles. Load data is valid in the same cycle. A store takes effect at that cycle's edge.
- Clean miss, request at cycle 0:
  - cycles 0..k: cpu_stall_o = 1.
  - cycle 1: mem_enable_o = 1.
  - cycle k: mem_ack_i = 1; line installed at the end of cycle k.
  - cycle k+1: REFILLED, stall = 0.
- Dirty miss: the WRITEBACK phase precedes the fill. The fill request is issued in the cycle after the write-back ack.
- Back-to-back requests are allowed. A request in REFILLED's successor cycle (IDLE) is evaluated normally.

## Structure
- dcache_pkg holds:
  - the state enum (IDLE, WRITEBACK, READMISS, REFILLED);
  - TAG_W = 22, INDEX_W = 5, OFFSET_W = 5, LINE_BITS = 256;
  - the address-field slicing constants.
- Sub-module dcache_sram holds the tag, valid, dirty and data arrays. It provides an asynchronous read, a synchronous write, a full-line write port and a word-merge write port, and clears valid/dirty on reset.
- dcache_controller holds the FSM, hit logic and memory-interface registers.

## Test plan
- Reset, then load 0x0000_0040 → stall = 1 in cycle 0; mem_enable_o = 1, mem_write_o = 0, mem_addr_o = 0x0000_0040 in cycle 1; ack after 4 cycles with word 0 = 0xDEAD_BEEF → stall drops the cycle after ack and cpu_data_o = 0xDEAD_BEEF.
- Store 0x1234_5678 to 0x0000_0044 after that fill → no stall; a following load of 0x0000_0044 returns 0x1234_5678 and the line is dirty.
- Load 0x0000_0440 (same index, tag 1) with the dirty line resident → write-back to 0x0000_0040 carrying 0x1234_5678 in word 1; after its ack, a fill request to 0x0000_0440 is issued.
- Store miss to a clean line at 0x0000_0080 → fill, then the word is merged in REFILLED; dirty = 1; a subsequent load of the same word returns the store value.
- Assert rst_i low while in READMISS → mem_enable_o = 0 immediately; after release, a load of the previous address misses again.
- Pulse mem_ack_i in IDLE with no request → no state change and no array update.
